// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver: per-frame snapshot of the
// displayed word, anti-ghosting dead time and optional leading-zero blanking.
module seg7_scan_driver #(
   parameter int PRESCALE_W   = 18,
   parameter int BLANK_CYCLES = 4,
   parameter bit LEAD_BLANK   = 1'b0
) (
   input  logic        cclk,
   input  logic        clr,
   input  logic [15:0] x,
   input  logic [3:0]  dp_in,
   output logic [6:0]  a_to_g,
   output logic [3:0]  an,
   output logic        dp,
   output logic        frame_tick
);

   localparam logic [PRESCALE_W-1:0] BLANK_LIM = PRESCALE_W'(BLANK_CYCLES);

   logic [PRESCALE_W-1:0] cnt_p0;
   logic [1:0]            digit_p0;
   logic [15:0]           shadow_x_p0;
   logic [3:0]            shadow_dp_p0;

   logic                  slot_end;
   logic                  frame_end;
   logic [3:0]            nib;
   logic                  upper_zero;
   logic                  blank;
   logic [6:0]            seg_nxt;
   logic [3:0]            an_nxt;
   logic                  dp_nxt;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   assign slot_end  = &cnt_p0;
   assign frame_end = slot_end && (digit_p0 == 2'd3);

   // Stage p0: refresh counter, digit select and frame snapshot
   always_ff @(posedge cclk or negedge clr) begin
      if (!clr) begin
         cnt_p0       <= '0;
         digit_p0     <= 2'd0;
         shadow_x_p0  <= 16'h0000;
         shadow_dp_p0 <= 4'h0;
      end else begin
         cnt_p0 <= cnt_p0 + 1'b1;
         if (slot_end) begin
            digit_p0 <= digit_p0 + 1'b1;
         end
         if (frame_end) begin
            shadow_x_p0  <= x;
            shadow_dp_p0 <= dp_in;
         end
      end
   end

   always_comb begin
      nib        = shadow_x_p0[{digit_p0, 2'b00} +: 4];
      upper_zero = 1'b0;
      case (digit_p0)
         2'd1:    upper_zero = (shadow_x_p0[15:4]  == 12'h000);
         2'd2:    upper_zero = (shadow_x_p0[15:8]  == 8'h00);
         2'd3:    upper_zero = (shadow_x_p0[15:12] == 4'h0);
         default: upper_zero = 1'b0;
      endcase
      blank   = (cnt_p0 < BLANK_LIM) || (LEAD_BLANK && upper_zero);
      seg_nxt = 7'b1111111;
      an_nxt  = 4'b1111;
      dp_nxt  = 1'b1;
      if (!blank) begin
         seg_nxt = hex_to_seg(nib);
         an_nxt  = ~(4'b0001 << digit_p0);
         dp_nxt  = ~shadow_dp_p0[digit_p0];
      end
   end

   // Stage p1: registered display outputs
   always_ff @(posedge cclk or negedge clr) begin
      if (!clr) begin
         a_to_g     <= 7'b1111111;
         an         <= 4'b1111;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         a_to_g     <= seg_nxt;
         an         <= an_nxt;
         dp         <= dp_nxt;
         frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 8-cycle digit slot, 32-cycle frame,
// one instance without and one with leading-zero blanking.
module tb_seg7_scan_driver;

   logic        cclk;
   logic        clr;
   logic [15:0] x;
   logic [3:0]  dp_in;
   logic [6:0]  a_to_g;
   logic [3:0]  an;
   logic        dp;
   logic        frame_tick;

   logic [15:0] x_lb;
   logic [3:0]  dp_in_lb;
   logic [6:0]  a_to_g_lb;
   logic [3:0]  an_lb;
   logic        dp_lb;
   logic        frame_tick_lb;

   int n_cmp;
   int n_err;
   int k;
   bit track_ft;
   int ft_n;
   int ft_pos [4];

   seg7_scan_driver #(.PRESCALE_W(3), .BLANK_CYCLES(1), .LEAD_BLANK(1'b0)) dut (
      .cclk(cclk), .clr(clr), .x(x), .dp_in(dp_in),
      .a_to_g(a_to_g), .an(an), .dp(dp), .frame_tick(frame_tick)
   );

   seg7_scan_driver #(.PRESCALE_W(3), .BLANK_CYCLES(1), .LEAD_BLANK(1'b1)) dut_lb (
      .cclk(cclk), .clr(clr), .x(x_lb), .dp_in(dp_in_lb),
      .a_to_g(a_to_g_lb), .an(an_lb), .dp(dp_lb), .frame_tick(frame_tick_lb)
   );

   initial begin
      cclk = 1'b0;
      forever #5 cclk = ~cclk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // k counts rising edges since the last reset release; sampled 1 time unit after the edge
   task automatic tick();
      @(posedge cclk);
      #1;
      k++;
      if (track_ft && frame_tick) begin
         if (ft_n < 4) ft_pos[ft_n] = k;
         ft_n++;
      end
   endtask

   task automatic run_to(input int target);
      while (k < target) tick();
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      k        = 0;
      track_ft = 1'b0;
      ft_n     = 0;
      clr      = 1'b1;
      x        = 16'h1234;
      dp_in    = 4'b0100;
      x_lb     = 16'h0050;
      dp_in_lb = 4'b0000;

      // asynchronous reset, checked before any clock edge
      #2 clr = 1'b0;
      #1;
      chk("rst_an",     16'(an),         16'(4'b1111));
      chk("rst_seg",    16'(a_to_g),     16'(7'b1111111));
      chk("rst_dp",     16'(dp),         16'(1'b1));
      chk("rst_ft",     16'(frame_tick), 16'(1'b0));
      chk("rst_lb_an",  16'(an_lb),      16'(4'b1111));

      @(posedge cclk);
      @(posedge cclk);
      #1;
      clr      = 1'b1;
      k        = 0;
      track_ft = 1'b1;

      // frame 0: shadow is zero
      run_to(1);
      chk("f0_dead_an", 16'(an), 16'(4'b1111));
      run_to(2);
      chk("f0_d0_an",   16'(an),     16'(4'b1110));
      chk("f0_d0_seg",  16'(a_to_g), 16'(7'b0000001));
      chk("f0_d0_dp",   16'(dp),     16'(1'b1));
      chk("lb_f0_d0_an",  16'(an_lb),     16'(4'b1110));
      chk("lb_f0_d0_seg", 16'(a_to_g_lb), 16'(7'b0000001));
      run_to(10);
      chk("f0_d1_an",   16'(an),     16'(4'b1101));
      chk("f0_d1_seg",  16'(a_to_g), 16'(7'b0000001));
      chk("lb_f0_d1_an",  16'(an_lb),     16'(4'b1111));
      chk("lb_f0_d1_seg", 16'(a_to_g_lb), 16'(7'b1111111));
      run_to(26);
      chk("f0_d3_an",   16'(an),     16'(4'b0111));
      chk("f0_d3_seg",  16'(a_to_g), 16'(7'b0000001));
      run_to(31);
      chk("ft_before",  16'(frame_tick), 16'(1'b0));
      run_to(32);
      chk("ft_first",   16'(frame_tick), 16'(1'b1));
      chk("lb_ft_first", 16'(frame_tick_lb), 16'(1'b1));

      // frame 1: shadow 1234, dp on digit 2
      run_to(33);
      chk("ft_after",   16'(frame_tick), 16'(1'b0));
      chk("f1_dead_an", 16'(an),     16'(4'b1111));
      chk("f1_dead_seg",16'(a_to_g), 16'(7'b1111111));
      run_to(34);
      chk("f1_d0_an",   16'(an),     16'(4'b1110));
      chk("f1_d0_seg",  16'(a_to_g), 16'(7'b1001100));
      chk("f1_d0_dp",   16'(dp),     16'(1'b1));
      chk("lb_f1_d0_an",  16'(an_lb),     16'(4'b1110));
      chk("lb_f1_d0_seg", 16'(a_to_g_lb), 16'(7'b0000001));
      run_to(40);
      chk("f1_d0_last_an", 16'(an), 16'(4'b1110));
      x_lb = 16'h0000;
      run_to(41);
      chk("f1_d1_dead_an", 16'(an), 16'(4'b1111));
      run_to(42);
      chk("f1_d1_an",   16'(an),     16'(4'b1101));
      chk("f1_d1_seg",  16'(a_to_g), 16'(7'b0000110));
      chk("lb_f1_d1_an",  16'(an_lb),     16'(4'b1101));
      chk("lb_f1_d1_seg", 16'(a_to_g_lb), 16'(7'b0100100));
      run_to(50);
      chk("f1_d2_an",   16'(an),     16'(4'b1011));
      chk("f1_d2_seg",  16'(a_to_g), 16'(7'b0010010));
      chk("f1_d2_dp",   16'(dp),     16'(1'b0));
      chk("lb_f1_d2_an",  16'(an_lb),     16'(4'b1111));
      chk("lb_f1_d2_seg", 16'(a_to_g_lb), 16'(7'b1111111));
      chk("lb_f1_d2_dp",  16'(dp_lb),     16'(1'b1));
      run_to(58);
      chk("f1_d3_an",   16'(an),     16'(4'b0111));
      chk("f1_d3_seg",  16'(a_to_g), 16'(7'b1001111));
      chk("f1_d3_dp",   16'(dp),     16'(1'b1));
      chk("lb_f1_d3_an",  16'(an_lb), 16'(4'b1111));

      // frame 2 repeats 1234; x changes mid-frame during digit 2
      run_to(66);
      chk("f2_d0_seg",  16'(a_to_g), 16'(7'b1001100));
      chk("lb_f2_d0_an",  16'(an_lb),     16'(4'b1110));
      chk("lb_f2_d0_seg", 16'(a_to_g_lb), 16'(7'b0000001));
      run_to(74);
      chk("lb_f2_d1_an",  16'(an_lb), 16'(4'b1111));
      run_to(82);
      chk("f2_d2_seg",  16'(a_to_g), 16'(7'b0010010));
      chk("lb_f2_d2_an",  16'(an_lb), 16'(4'b1111));
      x = 16'hABCD;
      run_to(90);
      chk("f2_d3_notear_an",  16'(an),     16'(4'b0111));
      chk("f2_d3_notear_seg", 16'(a_to_g), 16'(7'b1001111));
      chk("lb_f2_d3_an",  16'(an_lb), 16'(4'b1111));

      // frame 3: shadow ABCD
      run_to(98);
      chk("f3_d0_an",   16'(an),     16'(4'b1110));
      chk("f3_d0_seg",  16'(a_to_g), 16'(7'b1000010));
      run_to(106);
      chk("f3_d1_seg",  16'(a_to_g), 16'(7'b0110001));
      run_to(114);
      chk("f3_d2_seg",  16'(a_to_g), 16'(7'b1100000));
      chk("f3_d2_dp",   16'(dp),     16'(1'b0));
      run_to(122);
      chk("f3_d3_seg",  16'(a_to_g), 16'(7'b0001000));
      run_to(128);
      track_ft = 1'b0;
      chk("ft_count", 16'(ft_n), 16'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ft_pos%0d", i), 16'(ft_pos[i]), 16'(32 * (i + 1)));
      end

      // mid-scan reset in cycle 13 of frame 4
      run_to(141);
      chk("f4_pre_an",  16'(an),     16'(4'b1101));
      chk("f4_pre_seg", 16'(a_to_g), 16'(7'b0110001));
      #2 clr = 1'b0;
      #1;
      chk("mid_rst_an",  16'(an),         16'(4'b1111));
      chk("mid_rst_seg", 16'(a_to_g),     16'(7'b1111111));
      chk("mid_rst_dp",  16'(dp),         16'(1'b1));
      chk("mid_rst_ft",  16'(frame_tick), 16'(1'b0));
      @(posedge cclk);
      #1;
      clr = 1'b1;
      k   = 0;

      run_to(1);
      chk("rr_dead_an", 16'(an), 16'(4'b1111));
      run_to(2);
      chk("rr_d0_an",   16'(an),     16'(4'b1110));
      chk("rr_d0_seg",  16'(a_to_g), 16'(7'b0000001));
      run_to(10);
      chk("rr_d1_an",   16'(an),     16'(4'b1101));
      chk("rr_d1_seg",  16'(a_to_g), 16'(7'b0000001));
      chk("lb_rr_d1_an", 16'(an_lb), 16'(4'b1111));
      run_to(31);
      chk("rr_ft_before", 16'(frame_tick), 16'(1'b0));
      run_to(32);
      chk("rr_ft",        16'(frame_tick), 16'(1'b1));
      run_to(34);
      chk("rr_f1_d0_seg", 16'(a_to_g), 16'(7'b1000010));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
